// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling, one-cycle
// valid / framing-error pulses and activity LEDs.
module uart_rx #(
  parameter int CLOCK_FREQ = 4800,
  parameter int BAUD_RATE  = 1200
) (
  input  logic       ext_clock,
  input  logic       reset_n,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_error,
  output logic       rx_busy,
  output logic       uart_rx_led,
  output logic       uart_clock_led
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 4) begin : g_param_check
    $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be >= 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               rxled_q, rxled_d;
  logic               sync1_q, rx_s;
  logic [CNT_W-1:0]   ledcnt_q;
  logic               clkled_q;

  wire half_hit = (cnt_q == CNT_W'(HALF_BIT - 1));
  wire bit_hit  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge ext_clock) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      rx_s     <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      rxled_q  <= 1'b0;
      ledcnt_q <= '0;
      clkled_q <= 1'b0;
    end else begin
      sync1_q  <= uart_rx_pin;
      rx_s     <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      rxled_q  <= rxled_d;
      // Bit-rate heartbeat, only advancing while a frame is in progress
      if (rx_busy) begin
        if (ledcnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          ledcnt_q <= '0;
          clkled_q <= ~clkled_q;
        end else begin
          ledcnt_q <= ledcnt_q + 1'b1;
        end
      end else begin
        ledcnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    rxled_d = rxled_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (half_hit) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_hit) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            bit_d   = bit_q;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_hit) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            rxled_d = ~rxled_q;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK_WAIT;
          end
        end
      end
      BREAK_WAIT: begin
        // A held-low line must go high before a new start bit is accepted
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data        = data_q;
  assign rx_valid       = valid_q;
  assign rx_frame_error = ferr_q;
  assign rx_busy        = (state_q != IDLE);
  assign uart_rx_led    = rxled_q;
  assign uart_clock_led = clkled_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 4 clocks per bit: reset, single byte,
// back-to-back string, glitch, framing error/break, mid-frame reset.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_error, rx_busy, uart_rx_led, uart_clock_led;

  uart_rx #(.CLOCK_FREQ(4800), .BAUD_RATE(1200)) dut (
    .ext_clock      (clk),
    .reset_n        (reset_n),
    .uart_rx_pin    (pin),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_frame_error (rx_frame_error),
    .rx_busy        (rx_busy),
    .uart_rx_led    (uart_rx_led),
    .uart_clock_led (uart_clock_led)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0] got_q[$];
  int   n_err        = 0;
  int   n_viol       = 0;
  int   n_clkled_tgl = 0;
  int   valid_cyc    = -1;
  bit   busy_seen    = 1'b0;
  logic prev_valid   = 1'b0;
  logic prev_err     = 1'b0;
  logic prev_clkled  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      got_q.push_back(rx_data);
      valid_cyc = cyc;
    end
    if (rx_frame_error) n_err++;
    if (rx_valid && rx_frame_error) n_viol++;
    if (rx_valid && prev_valid) n_viol++;
    if (rx_frame_error && prev_err) n_viol++;
    if (uart_clock_led != prev_clkled) n_clkled_tgl++;
    if (rx_busy) busy_seen = 1'b1;
    prev_valid  = rx_valid;
    prev_err    = rx_frame_error;
    prev_clkled = uart_clock_led;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    pin = v;
    clocks(4);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  logic [7:0] hello [11] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};
  int c0;
  int err0;
  int n_before;

  initial begin
    // Reset with idle line
    reset_n = 1'b0;
    pin     = 1'b1;
    clocks(5);
    @(negedge clk);
    chk("rst_data",   rx_data, 8'h00);
    chk("rst_valid",  rx_valid, 0);
    chk("rst_ferr",   rx_frame_error, 0);
    chk("rst_busy",   rx_busy, 0);
    chk("rst_rxled",  uart_rx_led, 0);
    chk("rst_clkled", uart_clock_led, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    busy_seen = 1'b0;
    clocks(10);
    chk("idle_busy", busy_seen, 0);

    // Single byte 'h': line falls after edge c0, rx_s low 2 edges later,
    // IDLE sees it on edge c0+3, rx_valid rises on edge c0+3+38
    got_q.delete();
    n_clkled_tgl = 0;
    c0 = cyc;
    send_byte(8'h68, 1'b1);
    clocks(8);
    chk("h_count",   got_q.size(), 1);
    chk("h_data",    rx_data, 8'h68);
    chk("h_latency", valid_cyc - c0, 41);
    chk("h_rxled",   uart_rx_led, 1);
    chk("h_ferr",    n_err, 0);
    // busy for 38 cycles -> floor(38/4) heartbeat toggles
    chk("h_clkled_tgl", n_clkled_tgl, 9);

    // "hello world" back-to-back
    got_q.delete();
    for (int i = 0; i < 11; i++) send_byte(hello[i], 1'b1);
    clocks(8);
    chk("hw_count", got_q.size(), 11);
    for (int i = 0; i < 11; i++)
      chk($sformatf("hw_byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, hello[i]);
    chk("hw_ferr",  n_err, 0);
    chk("hw_rxled", uart_rx_led, 0);

    // One-clock glitch
    got_q.delete();
    busy_seen = 1'b0;
    pin = 1'b0;
    clocks(1);
    pin = 1'b1;
    clocks(12);
    chk("gl_busy_seen", busy_seen, 1);
    chk("gl_busy_end",  rx_busy, 0);
    chk("gl_valid",     got_q.size(), 0);
    chk("gl_ferr",      n_err, 0);

    // Framing error followed by break
    got_q.delete();
    err0 = n_err;
    send_byte(8'h55, 1'b0);
    pin = 1'b0;
    clocks(20);
    chk("fe_count", n_err - err0, 1);
    chk("fe_valid", got_q.size(), 0);
    chk("fe_data",  rx_data, 8'h64);
    chk("fe_busy",  rx_busy, 1);
    pin = 1'b1;
    clocks(6);
    chk("fe_busy_end", rx_busy, 0);
    send_byte(8'hA5, 1'b1);
    clocks(8);
    chk("fe_next_cnt",  got_q.size(), 1);
    chk("fe_next_data", rx_data, 8'hA5);

    // Mid-frame reset during bit 3 of 0xFF
    got_q.delete();
    err0 = n_err;
    drive_bit(1'b0);
    pin = 1'b1;
    clocks(14);
    reset_n = 1'b0;
    clocks(3);
    reset_n = 1'b1;
    clocks(30);
    chk("mr_valid", got_q.size(), 0);
    chk("mr_ferr",  n_err - err0, 0);
    chk("mr_busy",  rx_busy, 0);
    chk("mr_data",  rx_data, 8'h00);
    n_before = got_q.size();
    send_byte(8'h3C, 1'b1);
    clocks(8);
    chk("mr_next_cnt",  got_q.size() - n_before, 1);
    chk("mr_next_data", rx_data, 8'h3C);

    chk("pulse_rules", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
